multi_chan_delay_line: RTL and testbench

Parametrised multi-channel delay line, the successor to the fixed two-input register-and-shift datapath. It carries NCH channels of WIDTH bits plus a valid bit through a DEPTH-stage pipeline, with a run-time selectable delay, enable/stall, flush, and a derived AND-reduction channel. It sits between a capture stage and downstream consumers that need channels re-aligned by a programmable number of cycles.

---
 rtl/multi_chan_delay_line_pkg.sv | 25 ++
 rtl/multi_chan_delay_line_dly_stage_chain.sv | 30 +++
 rtl/multi_chan_delay_line.sv | 96 +++++++++
 tb/tb_multi_chan_delay_line.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_chan_delay_line_pkg.sv
// Shared constants and helpers for the multi-channel delay line.
package mcdl_pkg;

   localparam int DEFAULT_NCH   = 2;
   localparam int DEFAULT_WIDTH = 1;
   localparam int DEFAULT_DEPTH = 3;

   // Widest flattened channel vector that chan_slice can handle.
   localparam int MAX_VEC_W = 1024;

   function automatic int clamp_delay(input int sel, input int depth);
      return (sel < 1 || sel > depth) ? depth : sel;
   endfunction

   function automatic logic [MAX_VEC_W-1:0] chan_slice(
      input logic [MAX_VEC_W-1:0] vec,
      input int                   c,
      input int                   width = DEFAULT_WIDTH
   );
      logic [MAX_VEC_W-1:0] mask;
      mask = ~({MAX_VEC_W{1'b1}} << width);
      return (vec >> (c * width)) & mask;
   endfunction

endpackage

// File: rtl/multi_chan_delay_line_dly_stage_chain.sv
// Enable/flush shift chain; stage k is exposed at o_stages[k*W +: W].
module dly_stage_chain #(
   parameter int W     = 1,
   parameter int DEPTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_flush,
   input  logic             i_en,
   input  logic [W-1:0]     i_d,
   output logic [W*DEPTH-1:0] o_stages
);

   logic [W*DEPTH-1:0]     r_stages;
   logic [W*(DEPTH+1)-1:0] w_shifted;

   // Oldest stage falls off the top; this form also covers DEPTH=1.
   assign w_shifted = {r_stages, i_d};

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_stages <= '0;
      end else if (i_en) begin
         r_stages <= w_shifted[W*DEPTH-1:0];
      end
   end

   assign o_stages = r_stages;

endmodule

// File: rtl/multi_chan_delay_line.sv
// NCH-channel delay line with run-time tap select, stall, flush and AND channel.
module multi_chan_delay_line
   import mcdl_pkg::*;
#(
   parameter  int NCH   = DEFAULT_NCH,
   parameter  int WIDTH = DEFAULT_WIDTH,
   parameter  int DEPTH = DEFAULT_DEPTH,
   localparam int DW    = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 flush,
   input  logic [DW-1:0]        dly_sel,
   input  logic                 in_valid,
   input  logic [NCH*WIDTH-1:0] in_data,
   output logic                 out_valid,
   output logic [NCH*WIDTH-1:0] out_data,
   output logic [WIDTH-1:0]     out_and,
   output logic                 primed,
   output logic                 sel_err
);

   localparam int DATA_W = NCH * WIDTH;
   localparam int CW     = DATA_W + 1;

   logic [CW*DEPTH-1:0]    w_stages;
   logic [CW-1:0]          w_tap;
   logic [MAX_VEC_W-1:0]   w_tap_ext;
   logic [WIDTH-1:0]       w_and;
   logic                   w_sel_oor;
   int                     w_d;
   logic [DW-1:0]          r_prime_cnt;
   logic                   r_sel_err;

   // Bit 0 of every stage is the valid flag.
   dly_stage_chain #(
      .W     (CW),
      .DEPTH (DEPTH)
   ) u_chain (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_flush  (flush),
      .i_en     (en),
      .i_d      ({in_data, in_valid}),
      .o_stages (w_stages)
   );

   always_comb begin
      w_d = clamp_delay(int'(dly_sel), DEPTH);
   end

   assign w_sel_oor = (dly_sel == '0) || (int'(dly_sel) > DEPTH);

   always_comb begin
      w_tap = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (k + 1 == w_d) begin
            w_tap = w_stages[k*CW +: CW];
         end
      end
   end

   always_comb begin
      w_tap_ext             = '0;
      w_tap_ext[DATA_W-1:0] = w_tap[CW-1:1];
      w_and                 = '1;
      for (int c = 0; c < NCH; c++) begin
         w_and = w_and & WIDTH'(chan_slice(w_tap_ext, c, WIDTH));
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_prime_cnt <= '0;
      end else if (en && (r_prime_cnt != DW'(DEPTH))) begin
         r_prime_cnt <= r_prime_cnt + 1'b1;
      end
   end

   // Flush leaves this flag alone; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sel_err <= 1'b0;
      end else begin
         r_sel_err <= w_sel_oor;
      end
   end

   assign out_valid = w_tap[0];
   assign out_data  = w_tap[0] ? w_tap[CW-1:1] : '0;
   assign out_and   = w_tap[0] ? w_and : '0;
   assign primed    = int'(r_prime_cnt) >= w_d;
   assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_multi_chan_delay_line.sv
// Bench for multi_chan_delay_line: vector table, queue model with random traffic, DEPTH=4 select checks.
module tb_multi_chan_delay_line;
   import mcdl_pkg::*;

   localparam int NCH    = DEFAULT_NCH;
   localparam int WIDTH  = 4;
   localparam int DEPTH  = DEFAULT_DEPTH;
   localparam int DATA_W = NCH * WIDTH;

   logic              clk = 1'b0;
   logic              rst, flush, en, in_valid;
   logic [1:0]        dly_sel;
   logic [DATA_W-1:0] in_data;
   logic              out_valid, primed, sel_err;
   logic [DATA_W-1:0] out_data;
   logic [WIDTH-1:0]  out_and;

   logic       t4_rst, t4_flush, t4_en, t4_v;
   logic [2:0] t4_dly;
   logic [3:0] t4_data, t4_od, t4_oand;
   logic       t4_ov, t4_pr, t4_se;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   multi_chan_delay_line #(.NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .dly_sel(dly_sel),
      .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid),
      .out_data(out_data), .out_and(out_and), .primed(primed), .sel_err(sel_err)
   );

   multi_chan_delay_line #(.NCH(1), .WIDTH(4), .DEPTH(4)) u_dut4 (
      .clk(clk), .rst(t4_rst), .en(t4_en), .flush(t4_flush), .dly_sel(t4_dly),
      .in_valid(t4_v), .in_data(t4_data), .out_valid(t4_ov),
      .out_data(t4_od), .out_and(t4_oand), .primed(t4_pr), .sel_err(t4_se)
   );

   typedef struct packed {
      logic              v;
      logic [DATA_W-1:0] d;
   } ent_t;

   typedef struct {
      logic [2:0]        ctl;   // {rst, flush, en}
      logic [1:0]        dly;
      logic              v;
      logic [DATA_W-1:0] data;
      logic              ev;
      logic [DATA_W-1:0] ed;
      logic [WIDTH-1:0]  eand;
      logic              ep;
      logic              es;
   } row_t;

   row_t rows[$];
   ent_t m_q[$];
   int   m_prime;
   logic m_serr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add_row(input logic [2:0] ctl, input logic [1:0] dly, input logic v,
                          input logic [7:0] data, input logic ev, input logic [7:0] ed,
                          input logic [3:0] eand, input logic ep, input logic es);
      row_t r;
      r.ctl = ctl; r.dly = dly; r.v = v; r.data = data;
      r.ev = ev; r.ed = ed; r.eand = eand; r.ep = ep; r.es = es;
      rows.push_back(r);
   endtask

   function automatic int model_d(input logic [1:0] sel);
      return (sel == 2'd0 || int'(sel) > DEPTH) ? DEPTH : int'(sel);
   endfunction

   task automatic model_update();
      ent_t e;
      if (rst) begin
         m_q.delete();
         m_prime = 0;
         m_serr  = 1'b0;
      end else begin
         m_serr = (dly_sel == 2'd0) || (int'(dly_sel) > DEPTH);
         if (flush) begin
            m_q.delete();
            m_prime = 0;
         end else if (en) begin
            e.v = in_valid;
            e.d = in_data;
            m_q.push_front(e);
            if (m_q.size() > DEPTH) void'(m_q.pop_back());
            if (m_prime < DEPTH) m_prime++;
         end
      end
   endtask

   task automatic model_check(input string tag);
      ent_t             e;
      int               md;
      logic [WIDTH-1:0] a;
      md = model_d(dly_sel);
      e  = (m_q.size() >= md) ? m_q[md-1] : '0;
      a  = '1;
      for (int c = 0; c < NCH; c++) a = a & e.d[c*WIDTH +: WIDTH];
      check({tag, "_m_valid"}, 32'(out_valid), 32'(e.v));
      check({tag, "_m_data"},  32'(out_data),  e.v ? 32'(e.d) : 32'd0);
      check({tag, "_m_and"},   32'(out_and),   e.v ? 32'(a) : 32'd0);
      check({tag, "_m_primed"}, 32'(primed),   32'(m_prime >= md));
      check({tag, "_m_selerr"}, 32'(sel_err),  32'(m_serr));
   endtask

   task automatic step(input logic r, input logic f, input logic e, input logic [1:0] d,
                       input logic v, input logic [DATA_W-1:0] dat, input string tag);
      rst = r; flush = f; en = e; dly_sel = d; in_valid = v; in_data = dat;
      @(posedge clk);
      model_update();
      #1;
      model_check(tag);
   endtask

   task automatic step4(input logic r, input logic e, input logic [2:0] d,
                        input logic v, input logic [3:0] dat);
      t4_rst = r; t4_flush = 1'b0; t4_en = e; t4_dly = d; t4_v = v; t4_data = dat;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; en = 1'b0; dly_sel = 2'd3; in_valid = 1'b0; in_data = '0;
      t4_rst = 1'b1; t4_flush = 1'b0; t4_en = 1'b0; t4_dly = 3'd4; t4_v = 1'b0; t4_data = '0;
      m_prime = 0; m_serr = 1'b0;

      // ctl={rst,flush,en}, dly, v, data | valid, data, and, primed, sel_err
      add_row(3'b100, 2'd3, 1'b0, 8'h00, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
      add_row(3'b001, 2'd3, 1'b1, 8'h11, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
      add_row(3'b001, 2'd3, 1'b1, 8'h22, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
      add_row(3'b001, 2'd3, 1'b1, 8'h33, 1'b1, 8'h11, 4'h1, 1'b1, 1'b0);
      add_row(3'b001, 2'd3, 1'b1, 8'h44, 1'b1, 8'h22, 4'h2, 1'b1, 1'b0);
      add_row(3'b100, 2'd3, 1'b0, 8'h00, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
      add_row(3'b001, 2'd3, 1'b1, 8'h11, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
      add_row(3'b001, 2'd3, 1'b1, 8'h22, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
      add_row(3'b000, 2'd3, 1'b1, 8'h99, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
      add_row(3'b000, 2'd3, 1'b1, 8'h99, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
      add_row(3'b001, 2'd3, 1'b1, 8'h33, 1'b1, 8'h11, 4'h1, 1'b1, 1'b0);
      add_row(3'b001, 2'd3, 1'b1, 8'h44, 1'b1, 8'h22, 4'h2, 1'b1, 1'b0);
      add_row(3'b000, 2'd3, 1'b0, 8'h00, 1'b1, 8'h22, 4'h2, 1'b1, 1'b0);
      add_row(3'b000, 2'd3, 1'b0, 8'h00, 1'b1, 8'h22, 4'h2, 1'b1, 1'b0);
      add_row(3'b000, 2'd1, 1'b0, 8'h00, 1'b1, 8'h44, 4'h4, 1'b1, 1'b0);
      add_row(3'b000, 2'd2, 1'b0, 8'h00, 1'b1, 8'h33, 4'h3, 1'b1, 1'b0);
      add_row(3'b001, 2'd1, 1'b1, 8'h5F, 1'b1, 8'h5F, 4'h5, 1'b1, 1'b0);
      add_row(3'b001, 2'd1, 1'b0, 8'hFF, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
      add_row(3'b001, 2'd3, 1'b0, 8'hFF, 1'b1, 8'h5F, 4'h5, 1'b1, 1'b0);
      add_row(3'b001, 2'd3, 1'b1, 8'h77, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
      add_row(3'b001, 2'd3, 1'b1, 8'h66, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
      add_row(3'b011, 2'd3, 1'b1, 8'hAA, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
      add_row(3'b001, 2'd3, 1'b0, 8'h00, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
      add_row(3'b001, 2'd3, 1'b0, 8'h00, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
      add_row(3'b001, 2'd3, 1'b0, 8'h00, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
      add_row(3'b001, 2'd3, 1'b1, 8'h11, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
      add_row(3'b001, 2'd3, 1'b1, 8'h22, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
      add_row(3'b001, 2'd3, 1'b1, 8'h33, 1'b1, 8'h11, 4'h1, 1'b1, 1'b0);
      add_row(3'b000, 2'd0, 1'b0, 8'h00, 1'b1, 8'h11, 4'h1, 1'b1, 1'b1);
      add_row(3'b000, 2'd2, 1'b0, 8'h00, 1'b1, 8'h22, 4'h2, 1'b1, 1'b0);
      add_row(3'b001, 2'd0, 1'b1, 8'h44, 1'b1, 8'h22, 4'h2, 1'b1, 1'b1);
      add_row(3'b100, 2'd0, 1'b0, 8'h00, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
      add_row(3'b010, 2'd0, 1'b0, 8'h00, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1);

      for (int i = 0; i < rows.size(); i++) begin
         step(rows[i].ctl[2], rows[i].ctl[1], rows[i].ctl[0], rows[i].dly,
              rows[i].v, rows[i].data, $sformatf("row%0d", i));
         check($sformatf("row%0d_valid", i),  32'(out_valid), 32'(rows[i].ev));
         check($sformatf("row%0d_data", i),   32'(out_data),  32'(rows[i].ed));
         check($sformatf("row%0d_and", i),    32'(out_and),   32'(rows[i].eand));
         check($sformatf("row%0d_primed", i), 32'(primed),    32'(rows[i].ep));
         check($sformatf("row%0d_selerr", i), 32'(sel_err),   32'(rows[i].es));
      end

      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 8'($urandom), $sformatf("rnd%0d", i));
      end

      // DEPTH=4 instance: selects above DEPTH are representable here.
      step4(1'b1, 1'b0, 3'd4, 1'b0, 4'h0);
      check("d4_reset_selerr", 32'(t4_se), 32'd0);
      check("d4_reset_valid",  32'(t4_ov), 32'd0);
      for (int i = 1; i <= 4; i++) step4(1'b0, 1'b1, 3'd4, 1'b1, 4'(i));
      check("d4_fill_data",   32'(t4_od), 32'h1);
      check("d4_fill_primed", 32'(t4_pr), 32'd1);
      t4_en = 1'b0; t4_dly = 3'd7;
      #1;
      check("d4_sel7_clamp",  32'(t4_od), 32'h1);
      check("d4_sel7_lag",    32'(t4_se), 32'd0);
      @(posedge clk); #1;
      check("d4_sel7_err",    32'(t4_se), 32'd1);
      check("d4_sel7_and",    32'(t4_oand), 32'h1);
      t4_dly = 3'd2;
      #1;
      check("d4_sel2_data",   32'(t4_od), 32'h3);
      check("d4_sel2_lag",    32'(t4_se), 32'd1);
      @(posedge clk); #1;
      check("d4_sel2_clear",  32'(t4_se), 32'd0);
      t4_dly = 3'd5;
      @(posedge clk); #1;
      check("d4_sel5_err",    32'(t4_se), 32'd1);
      check("d4_sel5_data",   32'(t4_od), 32'h1);
      check("d4_sel5_primed", 32'(t4_pr), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
